// File: rtl/traffic_light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_light_sequencer: times dwells, issues toggles, polices LEDs.      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module traffic_light_sequencer #(
  parameter logic [31:0] RED_TIME         = 32'd100,
  parameter logic [31:0] GREEN_TIME       = 32'd100,
  parameter logic [31:0] RESPONSE_TIMEOUT = 32'd4,
  parameter logic [31:0] TRANSIT_TIMEOUT  = 32'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       enable,
  input  logic       ped_request,
  input  logic       green_led,
  input  logic       amber_led,
  input  logic       red_led,
  output logic       toggle,
  output logic       ped_wait,
  output logic       fault,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DWELL_RED   = 3'd1,
    ST_DWELL_GREEN = 3'd2,
    ST_WAIT_AMBER  = 3'd3,
    ST_TRANSIT     = 3'd4,
    ST_FAULT       = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    L_DARK, L_RED, L_GREEN, L_GOING_RED, L_GOING_GREEN, L_ILLEGAL
  } light_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_target;   // 1: heading for green, 0: heading for red
  logic        r_toggle;
  logic        r_ped_wait;
  logic        r_fault;

  light_t w_light;
  light_t w_amber_exp;
  light_t w_goal;
  light_t w_origin;

  always_comb begin
    w_light = L_ILLEGAL;
    case ({red_led, amber_led, green_led})
      3'b100:  w_light = L_RED;
      3'b001:  w_light = L_GREEN;
      3'b010:  w_light = L_GOING_RED;
      3'b110:  w_light = L_GOING_GREEN;
      3'b000:  w_light = L_DARK;
      default: w_light = L_ILLEGAL;
    endcase
  end

  assign w_amber_exp = r_target ? L_GOING_GREEN : L_GOING_RED;
  assign w_goal      = r_target ? L_GREEN : L_RED;
  assign w_origin    = r_target ? L_RED : L_GREEN;

  // The pulse is held across ce=0 cycles and only presented while ce is high.
  assign toggle   = r_toggle & ce;
  assign ped_wait = r_ped_wait;
  assign fault    = r_fault;
  assign phase    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_target   <= 1'b0;
      r_toggle   <= 1'b0;
      r_ped_wait <= 1'b0;
      r_fault    <= 1'b0;
    end else if (ce) begin
      r_toggle <= 1'b0;
      if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;

      if (r_state != ST_FAULT && w_light == L_ILLEGAL) begin
        r_state <= ST_FAULT;
        r_cnt   <= '0;
        r_fault <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            case (w_light)
              L_RED: begin
                r_state    <= ST_DWELL_RED;
                r_cnt      <= '0;
                r_ped_wait <= 1'b0;
              end
              L_GREEN: begin
                r_state <= ST_DWELL_GREEN;
                r_cnt   <= '0;
              end
              L_GOING_GREEN: begin
                r_state  <= ST_TRANSIT;
                r_cnt    <= '0;
                r_target <= 1'b1;
              end
              L_GOING_RED: begin
                r_state  <= ST_TRANSIT;
                r_cnt    <= '0;
                r_target <= 1'b0;
              end
              default: ;
            endcase
          end
          ST_DWELL_RED: begin
            if (w_light != L_RED) begin
              r_state <= ST_FAULT;
              r_cnt   <= '0;
              r_fault <= 1'b1;
            end else if (r_cnt >= RED_TIME && enable) begin
              r_toggle <= 1'b1;
              r_state  <= ST_WAIT_AMBER;
              r_cnt    <= '0;
              r_target <= 1'b1;
            end
          end
          ST_DWELL_GREEN: begin
            if (w_light != L_GREEN) begin
              r_state <= ST_FAULT;
              r_cnt   <= '0;
              r_fault <= 1'b1;
            end else if (r_cnt >= GREEN_TIME && r_ped_wait && enable) begin
              r_toggle <= 1'b1;
              r_state  <= ST_WAIT_AMBER;
              r_cnt    <= '0;
              r_target <= 1'b0;
            end
          end
          ST_WAIT_AMBER: begin
            if (w_light == w_amber_exp) begin
              r_state <= ST_TRANSIT;
              r_cnt   <= '0;
            end else if (w_light != w_origin || r_cnt == RESPONSE_TIMEOUT) begin
              r_state <= ST_FAULT;
              r_cnt   <= '0;
              r_fault <= 1'b1;
            end
          end
          ST_TRANSIT: begin
            if (w_light == w_goal) begin
              r_state <= r_target ? ST_DWELL_GREEN : ST_DWELL_RED;
              r_cnt   <= '0;
              if (!r_target) r_ped_wait <= 1'b0;
            end else if (w_light != w_amber_exp || r_cnt == TRANSIT_TIMEOUT) begin
              r_state <= ST_FAULT;
              r_cnt   <= '0;
              r_fault <= 1'b1;
            end
          end
          ST_FAULT: ;
          default: begin
            r_state <= ST_FAULT;
            r_cnt   <= '0;
            r_fault <= 1'b1;
          end
        endcase
      end

      // A new request outranks the clear on entry to red.
      if (ped_request && r_state != ST_FAULT) r_ped_wait <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_light_sequencer: directed bench with a two-cycle light model.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       reset, ce, enable, ped_request;
  logic       green_led, amber_led, red_led;
  logic       toggle, ped_wait, fault;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  int ce_div   = 1;
  int ce_ph    = 0;

  logic       lm_rst, lm_ignore, force_gr;
  logic [1:0] lm_st, lm_cnt;
  logic       lm_pipe;
  localparam logic [1:0] LM_RED = 2'd0, LM_GG = 2'd1, LM_GREEN = 2'd2, LM_GR = 2'd3;

  always #5 clk = ~clk;

  traffic_light_sequencer #(
    .RED_TIME(32'd5), .GREEN_TIME(32'd100),
    .RESPONSE_TIMEOUT(32'd4), .TRANSIT_TIMEOUT(32'd64)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable), .ped_request(ped_request),
    .green_led(green_led), .amber_led(amber_led), .red_led(red_led),
    .toggle(toggle), .ped_wait(ped_wait), .fault(fault), .phase(phase)
  );

  // Light: toggle is registered, then the colour changes; amber lasts 3 ce cycles.
  always @(posedge clk) begin
    if (lm_rst) begin
      lm_st <= LM_RED; lm_pipe <= 1'b0; lm_cnt <= 2'd0;
    end else if (ce) begin
      lm_pipe <= toggle & ~lm_ignore;
      case (lm_st)
        LM_RED:   if (lm_pipe) begin lm_st <= LM_GG; lm_cnt <= 2'd0; end
        LM_GREEN: if (lm_pipe) begin lm_st <= LM_GR; lm_cnt <= 2'd0; end
        LM_GG:    if (lm_cnt == 2'd2) lm_st <= LM_GREEN; else lm_cnt <= lm_cnt + 2'd1;
        default:  if (lm_cnt == 2'd2) lm_st <= LM_RED; else lm_cnt <= lm_cnt + 2'd1;
      endcase
    end
  end

  assign red_led   = (lm_st == LM_RED) || (lm_st == LM_GG) || force_gr;
  assign amber_led = (lm_st == LM_GG) || (lm_st == LM_GR);
  assign green_led = (lm_st == LM_GREEN) || force_gr;

  task automatic step();
    @(negedge clk);
    ce_ph = (ce_ph + 1) % ce_div;
    ce = (ce_ph == 0);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; lm_rst = 1'b1;
    step(); step();
    reset = 1'b0; lm_rst = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] want, input int budget);
    int n = 0;
    while (phase !== want && n < budget) begin step(); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; lm_rst = 1'b1;
    step(); step();
    checks++; if (toggle !== 1'b0) begin failures++; $display("FAIL reset_toggle: got %b want 0", toggle); end
    checks++; if (ped_wait !== 1'b0) begin failures++; $display("FAIL reset_ped_wait: got %b want 0", ped_wait); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase: got %0d want 0", phase); end
    reset = 1'b0; lm_rst = 1'b0;
  endtask

  task automatic run_red_to_green(input int div);
    int t = 0, t3 = -1, ttog = -1, ntog = 0, bad_ce = 0, nfault = 0, nseq = 0;
    logic [2:0] last;
    logic [8:0] seqv = '0;
    wait_phase(3'd1, 10 * div + 10);
    checks++; if (phase !== 3'd1) begin failures++; $display("FAIL enter_dwell_red div=%0d: got %0d want 1", div, phase); end
    last = 3'd1;
    while (phase !== 3'd2 && t < 60 * div) begin
      step(); t++;
      if (toggle === 1'b1) begin ntog++; if (ttog < 0) ttog = t; end
      if (toggle === 1'b1 && ce !== 1'b1) bad_ce++;
      if (fault !== 1'b0) nfault++;
      if (phase !== last) begin
        if (t3 < 0 && phase === 3'd3) t3 = t;
        if (nseq < 3) seqv = {seqv[5:0], phase};
        nseq++; last = phase;
      end
    end
    checks++; if (t3 != 6 * div) begin failures++; $display("FAIL wait_amber_delay div=%0d: got %0d want %0d", div, t3, 6 * div); end
    checks++; if (ttog != 7 * div - 1) begin failures++; $display("FAIL toggle_delay div=%0d: got %0d want %0d", div, ttog, 7 * div - 1); end
    checks++; if (ntog != 1) begin failures++; $display("FAIL toggle_width div=%0d: got %0d want 1", div, ntog); end
    checks++; if (bad_ce != 0) begin failures++; $display("FAIL toggle_without_ce div=%0d: got %0d want 0", div, bad_ce); end
    checks++; if (seqv !== {3'd3, 3'd4, 3'd2} || nseq != 3) begin
      failures++; $display("FAIL phase_sequence div=%0d: got %o (%0d changes) want 342 (3)", div, seqv, nseq); end
    checks++; if (nfault != 0) begin failures++; $display("FAIL fault_during_cycle div=%0d: got %0d want 0", div, nfault); end
  endtask

  task automatic test_ped_request();
    int t = 10, early = 0;
    for (int k = 0; k < 10; k++) step();
    ped_request = 1'b1; step(); ped_request = 1'b0; t++;
    checks++; if (ped_wait !== 1'b1) begin failures++; $display("FAIL ped_wait_set: got %b want 1", ped_wait); end
    while (toggle !== 1'b1 && t < 150) begin step(); t++; end
    checks++; if (t != 101) begin failures++; $display("FAIL green_toggle_delay: got %0d want 101", t); end
    while (phase !== 3'd1 && t < 250) begin
      step(); t++;
      if (phase !== 3'd1 && ped_wait !== 1'b1) early++;
    end
    checks++; if (phase !== 3'd1 || ped_wait !== 1'b0) begin
      failures++; $display("FAIL ped_wait_clear: got phase=%0d ped_wait=%b want 1/0", phase, ped_wait); end
    checks++; if (early != 0) begin failures++; $display("FAIL ped_wait_early_clear: got %0d want 0", early); end
  endtask

  task automatic test_green_hold();
    int ntog = 0;
    wait_phase(3'd2, 100);
    checks++; if (phase !== 3'd2) begin failures++; $display("FAIL reach_green: got %0d want 2", phase); end
    for (int k = 0; k < 10000; k++) begin step(); if (toggle === 1'b1) ntog++; end
    checks++; if (ntog != 0 || phase !== 3'd2) begin
      failures++; $display("FAIL green_hold: got toggles=%0d phase=%0d want 0/2", ntog, phase); end
  endtask

  task automatic test_response_timeout();
    int t = 0, bad = 0;
    lm_ignore = 1'b1;
    ped_request = 1'b1; step(); ped_request = 1'b0;
    while (toggle !== 1'b1 && t < 20) begin step(); t++; end
    checks++; if (toggle !== 1'b1) begin failures++; $display("FAIL timeout_toggle: got %b want 1", toggle); end
    for (int k = 0; k < 4; k++) step();
    checks++; if (phase !== 3'd3 || fault !== 1'b0) begin
      failures++; $display("FAIL timeout_cnt4: got phase=%0d fault=%b want 3/0", phase, fault); end
    step();
    checks++; if (phase !== 3'd5 || fault !== 1'b1) begin
      failures++; $display("FAIL timeout_fault: got phase=%0d fault=%b want 5/1", phase, fault); end
    for (int k = 0; k < 1000; k++) begin
      step(); if (fault !== 1'b1 || phase !== 3'd5 || toggle !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fault_sticky: got %0d bad cycles want 0", bad); end
    lm_ignore = 1'b0;
    apply_reset();
    checks++; if (fault !== 1'b0 || phase !== 3'd0) begin
      failures++; $display("FAIL fault_reset_clear: got fault=%b phase=%0d want 0/0", fault, phase); end
  endtask

  task automatic test_illegal();
    int ntog = 0;
    wait_phase(3'd1, 20);
    step();
    force_gr = 1'b1; step();
    checks++; if (fault !== 1'b1 || phase !== 3'd5) begin
      failures++; $display("FAIL illegal_fault: got fault=%b phase=%0d want 1/5", fault, phase); end
    force_gr = 1'b0;
    for (int k = 0; k < 20; k++) begin step(); if (toggle !== 1'b0) ntog++; end
    checks++; if (ntog != 0) begin failures++; $display("FAIL illegal_toggle: got %0d want 0", ntog); end
  endtask

  task automatic test_ce_scaled();
    ce_div = 3;
    apply_reset();
    run_red_to_green(3);
    ce_div = 1;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    apply_reset();
    wait_phase(3'd1, 20);
    while (toggle !== 1'b1 && t < 20) begin step(); t++; end
    ped_request = 1'b1; step(); ped_request = 1'b0;
    step();
    checks++; if ({red_led, amber_led, green_led} !== 3'b110 || phase !== 3'd3 || ped_wait !== 1'b1) begin
      failures++; $display("FAIL mid_precondition: got leds=%b phase=%0d ped_wait=%b want 110/3/1",
                           {red_led, amber_led, green_led}, phase, ped_wait); end
    reset = 1'b1; step();
    checks++; if (toggle !== 1'b0 || ped_wait !== 1'b0 || fault !== 1'b0 || phase !== 3'd0) begin
      failures++; $display("FAIL mid_reset: got t=%b pw=%b f=%b ph=%0d want 0/0/0/0", toggle, ped_wait, fault, phase); end
    reset = 1'b0; step();
    checks++; if (phase !== 3'd4) begin failures++; $display("FAIL resync_transit: got %0d want 4", phase); end
    wait_phase(3'd2, 20);
    checks++; if (phase !== 3'd2 || fault !== 1'b0) begin
      failures++; $display("FAIL resync_green: got phase=%0d fault=%b want 2/0", phase, fault); end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; enable = 1'b1; ped_request = 1'b0;
    lm_rst = 1'b1; lm_ignore = 1'b0; force_gr = 1'b0;
    test_reset();
    run_red_to_green(1);
    test_ped_request();
    test_green_hold();
    test_response_timeout();
    test_illegal();
    test_ce_scaled();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
